// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite bus signals between a master and the scratch-RAM slave
interface ahb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_hsel;
    logic [ADDR_WIDTH-1:0] i_haddr;
    logic [1:0]            i_htrans;
    logic                  i_hwrite;
    logic [2:0]            i_hsize;
    logic [DATA_WIDTH-1:0] i_hwdata;
    logic                  i_hready;
    logic                  o_hreadyout;
    logic                  o_hresp;
    logic [DATA_WIDTH-1:0] o_hrdata;

    modport master (
        output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hwdata, i_hready,
        input  o_hreadyout, o_hresp, o_hrdata
    );

    modport slave (
        input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hwdata, i_hready,
        output o_hreadyout, o_hresp, o_hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave with word-organised RAM, wait states and two-cycle ERROR
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic            i_clk_ahb,
    input  logic            i_rstn_ahb,
    ahb_slave_mem_if.slave  bus
);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t                state, state_d;
    logic [IW-1:0]         idx_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic [3:0]            cnt, cnt_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  accept, illegal;
    logic [3:0]            lanes;

    // WAIT and ERR1 hold the bus, so only the remaining states can take a new address phase
    assign accept  = (state == IDLE || state == DATA || state == ERR2)
                   && bus.i_hsel && bus.i_htrans[1] && bus.i_hready;
    assign illegal = bus.i_hsize > 3'd2
                   || (bus.i_hsize == 3'd1 && bus.i_haddr[0])
                   || (bus.i_hsize == 3'd2 && bus.i_haddr[1:0] != 2'b00)
                   || (bus.i_haddr >> 2) >= ADDR_WIDTH'(MEM_DEPTH);
    assign lanes   = size_q == 2'd2 ? 4'hf
                   : size_q == 2'd1 ? (off_q[1] ? 4'hc : 4'h3)
                   : 4'b0001 << off_q;

    assign bus.o_hreadyout = !(state == WAIT || state == ERR1);
    assign bus.o_hresp     = state == ERR1 || state == ERR2;
    assign bus.o_hrdata    = (state == DATA && !write_q) ? mem[idx_q] : '0;

    // Next-state: WAIT counts down, ERR1 always proceeds to ERR2, others follow the accept rules
    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt;
        if (state == WAIT) begin
            state_d = cnt == 4'd0 ? DATA : WAIT;
            cnt_d   = cnt - 4'd1;
        end else if (state == ERR1) begin
            state_d = ERR2;
        end else if (accept) begin
            state_d = illegal ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
            cnt_d   = 4'(WAIT_STATES - 1);
        end
    end

    // State register and address-phase capture
    always_ff @(posedge i_clk_ahb) begin
        if (!i_rstn_ahb) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                idx_q   <= bus.i_haddr[IW+1:2];
                off_q   <= bus.i_haddr[1:0];
                size_q  <= bus.i_hsize[1:0];
                write_q <= bus.i_hwrite;
            end
        end
    end

    // Memory: cleared on reset, selected byte lanes written at the close of a write data phase
    always_ff @(posedge i_clk_ahb) begin
        if (!i_rstn_ahb) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (state == DATA && write_q) begin
            for (int b = 0; b < 4; b++)
                if (lanes[b]) mem[idx_q][8*b +: 8] <= bus.i_hwdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: table-driven and randomized checks of ahb_slave_mem against a byte-array model
module tb_ahb_slave_mem;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        which;
    logic        hsel, hwrite, stall;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata;
    logic        rdy, resp;
    logic [31:0] rdata;

    ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
    ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

    ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) dut0 (
        .i_clk_ahb(clk), .i_rstn_ahb(rstn), .bus(b0));
    ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(3)) dut3 (
        .i_clk_ahb(clk), .i_rstn_ahb(rstn), .bus(b3));

    assign b0.i_hsel   = hsel & ~which;
    assign b3.i_hsel   = hsel & which;
    assign b0.i_haddr  = haddr;
    assign b3.i_haddr  = haddr;
    assign b0.i_htrans = htrans;
    assign b3.i_htrans = htrans;
    assign b0.i_hwrite = hwrite;
    assign b3.i_hwrite = hwrite;
    assign b0.i_hsize  = hsize;
    assign b3.i_hsize  = hsize;
    assign b0.i_hwdata = hwdata;
    assign b3.i_hwdata = hwdata;
    assign b0.i_hready = b0.o_hreadyout & ~stall;
    assign b3.i_hready = b3.o_hreadyout & ~stall;
    assign rdy   = which ? b3.o_hreadyout : b0.o_hreadyout;
    assign resp  = which ? b3.o_hresp     : b0.o_hresp;
    assign rdata = which ? b3.o_hrdata    : b0.o_hrdata;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        stall;
        bit        chk;
        bit        exp_resp;
        bit [31:0] exp_rdata;
    } txn_t;

    txn_t     q[$];
    int       checks = 0;
    int       errors = 0;
    bit [7:0] mb [2][256];

    function automatic int ws(bit w);
        return w ? 3 : 0;
    endfunction

    function automatic bit legal(bit [2:0] s, bit [31:0] a);
        if (s > 2) return 0;
        if (a % (32'd1 << s) != 0) return 0;
        return a / 4 < 64;
    endfunction

    function automatic bit [31:0] rd(bit w, bit [31:0] a);
        int base = int'(a / 4) * 4;
        return {mb[w][base+3], mb[w][base+2], mb[w][base+1], mb[w][base]};
    endfunction

    function automatic txn_t mk(bit sel, bit [1:0] tr, bit wr, bit [2:0] sz, bit [31:0] a,
                                bit [31:0] d, bit st, bit er, bit [31:0] ed);
        txn_t t;
        t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz; t.addr = a; t.wdata = d;
        t.stall = st; t.chk = 1; t.exp_resp = er; t.exp_rdata = ed;
        return t;
    endfunction

    function automatic txn_t rnd();
        txn_t t;
        int off;
        t.sel   = $urandom_range(0, 9) != 0;
        t.trans = $urandom_range(0, 7) == 0 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        t.wr    = 1'($urandom_range(0, 1));
        t.size  = $urandom_range(0, 12) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
        off     = t.size == 0 ? int'($urandom_range(0, 3)) : t.size == 1 ? 2 * int'($urandom_range(0, 1)) : 0;
        if ($urandom_range(0, 9) == 0) off = int'($urandom_range(0, 3));
        t.addr  = 32'(int'($urandom_range(0, 67)) * 4 + off);
        t.wdata = $urandom;
        t.stall = 0;
        t.chk   = 0;
        t.exp_resp = 0;
        t.exp_rdata = 0;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic complete(input txn_t c, input int waits);
        bit ok = legal(c.size, c.addr);
        bit er;
        bit [31:0] ed;
        er = c.chk ? c.exp_resp : !ok;
        ed = c.chk ? c.exp_rdata : ((ok && !c.wr) ? rd(which, c.addr) : 32'd0);
        chk("waits", 32'(waits), 32'(ok ? ws(which) : 1));
        chk("hresp", 32'(resp), 32'(er));
        chk("hrdata", rdata, ed);
        if (ok && c.wr)
            for (int b = 0; b < (1 << c.size); b++)
                mb[which][c.addr + b] = c.wdata[8 * int'((c.addr + b) % 4) +: 8];
    endtask

    task automatic finish_fatal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "aborted");
    endtask

    // Pipelined AHB master: address of the next transfer overlaps the data phase of the current one
    task automatic run(input bit w);
        txn_t cur, nxt;
        bit   hc = 0, hn, r;
        int   waits = 0;
        which = w;
        hn = q.size() > 0;
        if (hn) nxt = q.pop_front();
        while (hc || hn) begin
            hsel   = hn && nxt.sel;
            htrans = hn ? nxt.trans : 2'b00;
            hwrite = hn && nxt.wr;
            hsize  = hn ? nxt.size : 3'd0;
            haddr  = hn ? nxt.addr : 32'd0;
            stall  = hn && nxt.stall;
            hwdata = hc ? cur.wdata : 32'd0;
            @(negedge clk);
            r = rdy;
            if (hc && !r) begin
                waits++;
                chk("wait_hresp", 32'(resp), 32'(!legal(cur.size, cur.addr)));
                chk("wait_hrdata", rdata, 32'd0);
                if (waits > 20) begin
                    errors++;
                    $display("FAIL timeout: hreadyout stuck low, got %0d wait cycles expected at most %0d", waits, 3);
                    finish_fatal();
                end
            end else if (hc) begin
                complete(cur, waits);
            end else begin
                chk("idle_hreadyout", 32'(rdy), 32'd1);
                chk("idle_hresp", 32'(resp), 32'd0);
                chk("idle_hrdata", rdata, 32'd0);
            end
            @(posedge clk);
            #1;
            if (r) begin
                hc = 0;
                if (hn) begin
                    if (nxt.sel && nxt.trans[1] && !nxt.stall) begin
                        cur = nxt;
                        hc = 1;
                        waits = 0;
                    end
                    hn = q.size() > 0;
                    if (hn) nxt = q.pop_front();
                end
            end
        end
        hsel = 0; htrans = 2'b00; stall = 0; hwdata = 0;
    endtask

    task automatic clear_model();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++) mb[w][i] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        errors++;
        finish_fatal();
    end

    initial begin
        txn_t t0[] = '{
            mk(1, 2'b10, 1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 0, 32'h0),
            mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0,        0, 0, 32'hDEADBEEF),
            mk(1, 2'b10, 1, 3'd2, 32'h10,  32'h11223344, 0, 0, 32'h0),
            mk(1, 2'b11, 1, 3'd0, 32'h11,  32'h0000AA00, 0, 0, 32'h0),
            mk(1, 2'b11, 0, 3'd2, 32'h10,  32'h0,        0, 0, 32'h1122AA44),
            mk(1, 2'b10, 1, 3'd1, 32'h12,  32'hBEEF0000, 0, 0, 32'h0),
            mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0,        0, 0, 32'hBEEFAA44),
            mk(1, 2'b10, 1, 3'd2, 32'h100, 32'hCAFEF00D, 0, 1, 32'h0),
            mk(1, 2'b10, 1, 3'd2, 32'h2,   32'hCAFEF00D, 0, 1, 32'h0),
            mk(1, 2'b10, 0, 3'd3, 32'h10,  32'h0,        0, 1, 32'h0),
            mk(1, 2'b10, 1, 3'd1, 32'h11,  32'h12341234, 0, 1, 32'h0),
            mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0,        0, 0, 32'hBEEFAA44),
            mk(1, 2'b10, 0, 3'd2, 32'h0,   32'h0,        0, 0, 32'h0),
            mk(0, 2'b10, 1, 3'd2, 32'h10,  32'h0,        0, 0, 32'h0),
            mk(1, 2'b00, 1, 3'd2, 32'h10,  32'h0,        0, 0, 32'h0),
            mk(1, 2'b01, 1, 3'd2, 32'h10,  32'h0,        0, 0, 32'h0),
            mk(1, 2'b10, 1, 3'd2, 32'h10,  32'h0,        1, 0, 32'h0),
            mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0,        0, 0, 32'hBEEFAA44)
        };
        txn_t t3[] = '{
            mk(1, 2'b10, 0, 3'd2, 32'h0,   32'h0,        0, 0, 32'h0),
            mk(1, 2'b10, 1, 3'd2, 32'h8,   32'hA5A55A5A, 0, 0, 32'h0),
            mk(1, 2'b10, 0, 3'd2, 32'h8,   32'h0,        0, 0, 32'hA5A55A5A),
            mk(1, 2'b10, 0, 3'd2, 32'h2,   32'h0,        0, 1, 32'h0),
            mk(1, 2'b10, 1, 3'd0, 32'hB,   32'h77000000, 0, 0, 32'h0),
            mk(1, 2'b10, 0, 3'd2, 32'h8,   32'h0,        0, 0, 32'h77A55A5A)
        };

        which = 0; hsel = 0; htrans = 2'b00; hwrite = 0; hsize = 3'd0;
        haddr = 0; hwdata = 0; stall = 0;
        clear_model();
        rstn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            which = 1'(w);
            #1;
            chk("reset_hreadyout", 32'(rdy), 32'd1);
            chk("reset_hresp", 32'(resp), 32'd0);
            chk("reset_hrdata", rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        rstn = 1;

        foreach (t3[i]) q.push_back(t3[i]);
        run(1);
        foreach (t0[i]) q.push_back(t0[i]);
        run(0);

        which = 1; hsel = 1; htrans = 2'b10; hwrite = 1; hsize = 3'd2; haddr = 32'h4;
        @(posedge clk);
        #1;
        hsel = 0; htrans = 2'b00; hwdata = 32'h12345678;
        @(negedge clk);
        chk("rst_wait_hreadyout", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        rstn = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_hreadyout", 32'(rdy), 32'd1);
        chk("rst_mid_hresp", 32'(resp), 32'd0);
        chk("rst_mid_hrdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1;
        hwdata = 0;
        clear_model();
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h4, 32'h0, 0, 0, 32'h0));
        run(1);

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 80; i++) q.push_back(rnd());
            run(1'(w));
            for (int a = 0; a < 64; a++) begin
                txn_t t = rnd();
                t.sel = 1; t.trans = 2'b10; t.wr = 0; t.size = 3'd2; t.addr = 32'(a * 4);
                q.push_back(t);
            end
            run(1'(w));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite slave with an internal word-organised register memory. It sits directly downstream of the AHB master on the AHB bus and terminates its transfers. It supports byte, halfword and word accesses, programmable wait states, and a two-cycle ERROR response for illegal accesses. It is used as the bus-side target for master bring-up and as a generic scratch RAM in the SoC.

Parameters:
ADDR_WIDTH, 32, width of i_haddr
DATA_WIDTH, 32, data bus width; fixed at 32 (4 byte lanes)
MEM_DEPTH, 64, number of 32-bit words; power of 2, minimum 2
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; range 0..15

Ports:
i_clk_ahb  in  1  AHB clock
i_rstn_ahb  in  1  synchronous active-low reset
i_hsel  in  1  slave select
i_haddr  in  ADDR_WIDTH  transfer address
i_htrans  in  2  transfer type; bit1=1 means NONSEQ/SEQ, i.e. an active transfer
i_hwrite  in  1  1=write, 0=read
i_hsize  in  3  0=byte, 1=half, 2=word
i_hwdata  in  DATA_WIDTH  write data, valid in the data phase
i_hready  in  1  bus HREADY, qualifies address-phase sampling
o_hreadyout  out  1  slave ready / data phase complete
o_hresp  out  1  0=OKAY, 1=ERROR
o_hrdata  out  DATA_WIDTH  read data

Behaviour:
- Reset values (synchronous, active-low): state=IDLE, o_hreadyout=1, o_hresp=0, o_hrdata=0, wait counter=0, all memory words=0. Reset asserted mid-transfer aborts it: no memory write, and outputs take reset values at the next edge.
- Address phase is accepted on a rising edge when i_hsel & i_htrans[1] & i_hready. On acceptance, haddr, hwrite and hsize are registered.
- If none of those conditions hold (unselected, IDLE/BUSY, or bus stalled), nothing is captured and the slave stays or returns to IDLE with o_hreadyout=1, o_hresp=0.
- Error check at acceptance. A transfer is illegal if any of the following holds:
  - i_hsize > 2
  - misaligned: size 1 with haddr[0]=1, or size 2 with haddr[1:0]!=0
  - haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH
- State IDLE:
  - legal accept: go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else go to DATA
  - illegal accept: go to ERR1
- State WAIT: o_hreadyout=0, o_hresp=0. Counter decrements each cycle; at 0, go to DATA. Exactly WAIT_STATES low-ready cycles occur.
- State DATA (completion cycle): o_hreadyout=1, o_hresp=0.
  - Read: o_hrdata = mem[addr_q] combinationally, full word regardless of size.
  - Write: byte lanes selected by size/addr_q are updated from i_hwdata at the closing edge; other lanes are unchanged.
  - Lane select: size 0 -> lane addr_q[1:0]; size 1 -> lanes {addr_q[1],0} and {addr_q[1],1}; size 2 -> all four lanes. Little-endian.
  - A new address phase may be accepted on this same edge (pipelined back-to-back). The next state follows the IDLE rules; otherwise go to IDLE.
- ERR1: o_hreadyout=0, o_hresp=1, no memory access, go to ERR2.
- ERR2: o_hreadyout=1, o_hresp=1, no memory access. An accept on this edge is handled per IDLE rules; otherwise go to IDLE.
- o_hrdata is 0 in every cycle that is not a read completion in DATA.
- Read-after-write to the same address, back-to-back: the write commits at the end of its data phase, so the read returns the new data.
- Latency from address accept to completion is WAIT_STATES+1 cycles. An ERROR response always takes 2 cycles.
- WAIT and ERR1 never accept a new address phase, since bus HREADY is low in those cycles.

Test Plan:
1. WAIT_STATES=0: word write 0xDEADBEEF @0x10, then back-to-back read @0x10 -> write completes with o_hreadyout=1 the cycle after its address phase; read data phase o_hrdata=0xDEADBEEF, o_hresp=0.
2. Byte write 0xAA (on i_hwdata[15:8]) @0x11 over word 0x11223344, then word read @0x10 -> o_hrdata=0x1122AA44. Halfword 0xBEEF @0x12 -> read gives 0xBEEFAA44.
3. WAIT_STATES=3: read @0x0 after reset -> exactly 3 cycles o_hreadyout=0, then 1 cycle o_hreadyout=1 with o_hrdata=0.
4. Illegal accesses (addr 0x100 with MEM_DEPTH=64; word @0x2; hsize=3) -> each gives one cycle {hreadyout=0, hresp=1} then one cycle {1,1}; a subsequent read shows memory unchanged.
5. Unselected or i_htrans=2'b00 cycles interleaved with transfers -> o_hreadyout=1, o_hresp=0, no memory change.
6. Reset asserted during a WAIT of a word write 0x12345678 @0x4 -> next cycle outputs at reset values; a read @0x4 after reset returns 0.
